// File: rtl/hilbert_pkg.sv
// Shared defaults and the capture state type for the FFT frame capture block.
package hilbert_pkg;
  localparam int total_bits = 32;
  localparam int N          = 32;
  localparam int idx_w      = $clog2(N);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;
endpackage

// File: rtl/frame_buf_ram.sv
// Simple dual-port frame buffer: one write port and one registered read port on CLK.
module frame_buf_ram #(
  parameter int W      = 64,
  parameter int DEPTH  = 32,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);
  logic [W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset; only the read register does, so the
  // readout comes up as zero while the array maps onto plain RAM.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/fft_frame_capture.sv
// Captures one transform output frame and streams it out in bin order over valid/ready.
// Define FRAME_PEAK_EN to add PEAK_IDX/PEAK_VALID (bin with largest |re|+|im|).
module fft_frame_capture
  import hilbert_pkg::*;
#(
  parameter int total_bits = hilbert_pkg::total_bits,
  parameter int N          = hilbert_pkg::N,
  localparam int IW        = $clog2(N)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  ED,
  input  logic                  RDY,
  input  logic [total_bits-1:0] DIReal,
  input  logic [total_bits-1:0] DIImag,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [total_bits-1:0] M_REAL,
  output logic [total_bits-1:0] M_IMAG,
  output logic [IW-1:0]         M_INDEX,
  output logic                  M_LAST,
  output logic                  BUSY,
  output logic [7:0]            DROP_CNT
`ifdef FRAME_PEAK_EN
  ,
  output logic [IW-1:0]         PEAK_IDX,
  output logic                  PEAK_VALID
`endif
);
  state_t                  state, state_nxt;
  logic [IW-1:0]           wr_idx;
  logic                    drain_wait;
  logic                    wr_en, rd_en;
  logic [IW-1:0]           wr_addr, rd_addr;
  logic [2*total_bits-1:0] rd_data;
  logic                    last_xfer;

  assign M_LAST    = M_VALID && (M_INDEX == IW'(N - 1));
  assign last_xfer = M_VALID && M_READY && M_LAST;
  assign BUSY      = (state != IDLE);
  assign M_REAL    = rd_data[2*total_bits-1:total_bits];
  assign M_IMAG    = rd_data[total_bits-1:0];

  frame_buf_ram #(.W(2*total_bits), .DEPTH(N)) u_buf (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({DIReal, DIImag}),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // NOTE: the state register uses non-blocking assignments so every flop samples
  // pre-edge values; the next-state logic below is purely combinational.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // value unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_addr   = wr_idx;
    rd_en     = 1'b0;
    rd_addr   = '0;
    case (state)
      IDLE: begin
        if (ED && RDY) begin
          wr_en     = 1'b1;
          wr_addr   = '0;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (ED) begin
          wr_en = 1'b1;
          if (RDY)                          wr_addr   = '0;
          else if (wr_idx == IW'(N - 1))    state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        // One idle cycle after the final write, then keep the read register
        // refilled whenever the presented sample is empty or being taken.
        if (!drain_wait && (!M_VALID || (M_READY && !M_LAST))) begin
          rd_en   = 1'b1;
          rd_addr = M_VALID ? M_INDEX + 1'b1 : '0;
        end
        if (last_xfer) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_idx     <= '0;
      drain_wait <= 1'b0;
      M_VALID    <= 1'b0;
      M_INDEX    <= '0;
      DROP_CNT   <= '0;
    end else begin
      // Wraps to zero after index N-1, ready for the next frame.
      if (wr_en) wr_idx <= wr_addr + 1'b1;
      drain_wait <= (state == CAPTURE) && (state_nxt == DRAIN);
      if (rd_en) begin
        M_VALID <= 1'b1;
        M_INDEX <= rd_addr;
      end else if (state == DRAIN && last_xfer) begin
        M_VALID <= 1'b0;
        M_INDEX <= '0;
      end
      if (state == DRAIN && ED && RDY && DROP_CNT != 8'hFF)
        DROP_CNT <= DROP_CNT + 1'b1;
    end
  end

`ifdef FRAME_PEAK_EN
  logic [total_bits:0]   re_ext, im_ext, re_abs, im_abs;
  logic [total_bits+1:0] mag, peak_mag;

  // One extra bit keeps the magnitude of the most negative sample exact.
  always_comb begin
    re_ext = {DIReal[total_bits-1], DIReal};
    im_ext = {DIImag[total_bits-1], DIImag};
    re_abs = re_ext[total_bits] ? (~re_ext + 1'b1) : re_ext;
    im_abs = im_ext[total_bits] ? (~im_ext + 1'b1) : im_ext;
    mag    = {1'b0, re_abs} + {1'b0, im_abs};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      peak_mag   <= '0;
      PEAK_IDX   <= '0;
      PEAK_VALID <= 1'b0;
    end else begin
      if (wr_en) begin
        if (wr_addr == '0) begin
          peak_mag <= mag;
          PEAK_IDX <= '0;
        end else if (mag > peak_mag) begin
          peak_mag <= mag;
          PEAK_IDX <= wr_addr;
        end
      end
      if (rd_en && !M_VALID)                PEAK_VALID <= 1'b1;
      else if (state == DRAIN && last_xfer) PEAK_VALID <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_fft_frame_capture.sv
// Randomized self-checking bench for fft_frame_capture against a frame-level queue model.
// Define FRAME_PEAK_EN to also exercise the peak-bin outputs.
module tb_fft_frame_capture;
  localparam int TB = 32;
  localparam int N  = 32;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ed = 1'b0, rdy = 1'b0, m_ready = 1'b1;
  logic [TB-1:0] di_real = '0, di_imag = '0;
  logic          m_valid, m_last, busy;
  logic [TB-1:0] m_real, m_imag;
  logic [IW-1:0] m_index;
  logic [7:0]    drop_cnt;
`ifdef FRAME_PEAK_EN
  logic [IW-1:0] peak_idx;
  logic          peak_valid;
`endif

  fft_frame_capture #(.total_bits(TB), .N(N)) dut (
    .CLK(clk), .RST_N(rst_n), .ED(ed), .RDY(rdy),
    .DIReal(di_real), .DIImag(di_imag),
    .M_VALID(m_valid), .M_READY(m_ready), .M_REAL(m_real), .M_IMAG(m_imag),
    .M_INDEX(m_index), .M_LAST(m_last), .BUSY(busy), .DROP_CNT(drop_cnt)
`ifdef FRAME_PEAK_EN
    , .PEAK_IDX(peak_idx), .PEAK_VALID(peak_valid)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { longint re; longint im; int idx; } samp_t;
  samp_t  mq[$];
  longint fr_re[N], fr_im[N];
  int     cap_cnt, cyc, ready_at, drop, exp_peak;
  bit     capturing;

  function automatic longint mag_of(input longint re, input longint im);
    return (re < 0 ? -re : re) + (im < 0 ? -im : im);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      capturing = 0; cap_cnt = 0; drop = 0; cyc = 0; ready_at = 0; exp_peak = 0;
      mq.delete();
    end else begin
      if (mq.size() > 0) begin
        if (ed && rdy && drop < 255) drop++;
        if (cyc >= ready_at && m_ready) mq.delete(0);
      end else if (ed) begin
        if (rdy) begin
          fr_re[0] = $signed(di_real); fr_im[0] = $signed(di_imag);
          cap_cnt = 1; capturing = 1;
        end else if (capturing) begin
          fr_re[cap_cnt] = $signed(di_real); fr_im[cap_cnt] = $signed(di_imag);
          cap_cnt++;
          if (cap_cnt == N) begin
            capturing = 0;
            exp_peak  = 0;
            for (int i = 0; i < N; i++) begin
              mq.push_back('{re: fr_re[i], im: fr_im[i], idx: i});
              if (mag_of(fr_re[i], fr_im[i]) > mag_of(fr_re[exp_peak], fr_im[exp_peak]))
                exp_peak = i;
            end
            ready_at = cyc + 3;
          end
        end
      end
      cyc++;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit ev;
    if (rst_n) begin
      ev = (mq.size() > 0) && (cyc >= ready_at);
      check("m_valid", m_valid, ev);
      check("busy", busy, capturing || (mq.size() > 0));
      check("drop_cnt", drop_cnt, drop);
      check("m_last", m_last, ev && (mq[0].idx == N - 1));
      if (ev) begin
        check("m_real", $signed(m_real), mq[0].re);
        check("m_imag", $signed(m_imag), mq[0].im);
        check("m_index", m_index, mq[0].idx);
      end
`ifdef FRAME_PEAK_EN
      check("peak_valid", peak_valid, ev);
      if (ev) check("peak_idx", peak_idx, exp_peak);
`endif
    end
  end

  // Transfer log for literal checks; m_ready is stable from +2 to the next edge.
  typedef struct { longint re; longint im; int idx; bit last; } xfer_t;
  xfer_t got[$];
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready)
      got.push_back('{re: $signed(m_real), im: $signed(m_imag), idx: m_index, last: m_last});
  end

  // ---------------- stimulus helpers ----------------
  longint sent_re[N], sent_im[N];

  task automatic send(input logic [TB-1:0] re, input logic [TB-1:0] im, input logic e, input logic r);
    di_real = re; di_imag = im; ed = e; rdy = r;
    @(posedge clk); #2;
    ed = 1'b0; rdy = 1'b0;
  endtask

  task automatic send_frame(input bit ramp, input bit gaps);
    logic [TB-1:0] re, im;
    for (int i = 0; i < N; i++) begin
      re = ramp ? TB'(i) : $urandom;
      im = ramp ? TB'(-i) : $urandom;
      sent_re[i] = $signed(re); sent_im[i] = $signed(im);
      send(re, im, 1'b1, i == 0);
      if (gaps && i != N - 1) send('0, '0, 1'b0, 1'b0);
    end
  endtask

  task automatic wait_idle(input bit e, input int budget);
    int c = 0;
    while (busy && c < budget) begin
      send($urandom, $urandom, e, 1'b0);
      c++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic check_got();
    check("xfer_count", got.size(), N);
    for (int i = 0; i < N && i < got.size(); i++) begin
      check("log_idx", got[i].idx, i);
      check("log_re", got[i].re, sent_re[i]);
      check("log_im", got[i].im, sent_im[i]);
      check("log_last", got[i].last, i == N - 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Reset state
    #3;
    check("rst_valid", m_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_index", m_index, 0);
    check("rst_real", m_real, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // 1: ramp frame, full throughput
    got.delete();
    m_ready = 1'b1;
    send_frame(1'b1, 1'b0);
    wait_idle(1'b0, 100);
    check_got();
    check("ramp_lit_re5", got.size() > 5 ? got[5].re : -1, 5);
    check("ramp_lit_im5", got.size() > 5 ? got[5].im : 0, -5);

    // 2: enable gaps, latency from the final write
    got.delete();
    send_frame(1'b0, 1'b1);
    check("lat_edge1", m_valid, 0);
    send('0, '0, 1'b0, 1'b0);
    check("lat_edge1b", m_valid, 0);
    send('0, '0, 1'b0, 1'b0);
    check("lat_edge2", m_valid, 1);
    wait_idle(1'b0, 100);
    check_got();

    // 3: back-pressure 1,0,0,1 during readout
    got.delete();
    send_frame(1'b0, 1'b0);
    c = 0;
    while (busy && c < 300) begin
      m_ready = (c % 4 == 0) || (c % 4 == 3);
      send($urandom, $urandom, 1'b0, 1'b0);
      c++;
    end
    m_ready = 1'b1;
    check("bp_timeout", busy, 0);
    check_got();

    // 4: restart at capture index 10, then drops
    got.delete();
    for (int i = 0; i < 10; i++) send($urandom, $urandom, 1'b1, i == 0);
    send_frame(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send('0, '0, 1'b1, 1'b1);
      send('0, '0, 1'b0, 1'b0);
    end
    check("drop_three", drop_cnt, 3);
    m_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      send('0, '0, 1'b1, 1'b1);
      send('0, '0, 1'b0, 1'b0);
    end
    check("drop_sat", drop_cnt, 255);
    m_ready = 1'b1;
    wait_idle(1'b1, 100);
    check_got();

    // 5: reset during readout at index 5
    send_frame(1'b0, 1'b0);
    c = 0;
    while (!(m_valid && m_index == 5) && c < 100) begin
      send('0, '0, 1'b0, 1'b0);
      c++;
    end
    check("reach_idx5", m_index, 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_last", m_last, 0);
    check("mid_rst_index", m_index, 0);
    check("mid_rst_real", m_real, 0);
    check("mid_rst_imag", m_imag, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_drop", drop_cnt, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    send('0, '0, 1'b0, 1'b0);
    got.delete();
    send_frame(1'b0, 1'b0);
    wait_idle(1'b0, 100);
    check_got();

`ifdef FRAME_PEAK_EN
    // Peak: equal magnitudes at 7 and 20, lowest index wins
    for (int i = 0; i < N; i++) begin
      if (i == 7)       send(TB'(1000), TB'(-1000), 1'b1, 1'b0);
      else if (i == 20) send(TB'(-2000), '0, 1'b1, 1'b0);
      else              send('0, '0, 1'b1, i == 0);
    end
    c = 0;
    while (!m_valid && c < 10) begin
      check("peak_early", peak_valid, 0);
      send('0, '0, 1'b0, 1'b0);
      c++;
    end
    check("peak_idx_lit", peak_idx, 7);
    check("peak_valid_lit", peak_valid, 1);
    wait_idle(1'b0, 100);
    check("peak_clear", peak_valid, 0);
`endif

    // 6: random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      m_ready = ($urandom_range(0, 1) == 1);
      send($urandom, $urandom, $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end
    m_ready = 1'b1;
    wait_idle(1'b1, 200);
    send('0, '0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
